// File: rtl/dec_pkg.sv
// Shared types, mode encodings and H-matrix column generator for the SEC-DED syndrome locator.
package dec_pkg;

  typedef enum logic [1:0] {
    StClean   = 2'd0,
    StDataErr = 2'd1,
    StChkErr  = 2'd2,
    StUncorr  = 2'd3
  } dec_status_e;

  localparam logic [1:0] ModeW8  = 2'd0;
  localparam logic [1:0] ModeW16 = 2'd1;
  localparam logic [1:0] ModeW32 = 2'd2;
  localparam logic [1:0] ModeW64 = 2'd3;

  localparam int unsigned ModeLog2Base = 3;
  // Wide enough for the largest syndrome (64 data bits -> 7 bits).
  localparam int unsigned ColW = 7;

  function automatic int unsigned mode_log2(input logic [1:0] mode);
    return ModeLog2Base + 32'(mode);
  endfunction

  // Column i of the code with 2^width_log2 data bits: overall-parity bit at width_log2, then
  // one-hot low bits, a bare parity column, and finally the multi-bit values in ascending order.
  function automatic logic [ColW-1:0] dec_col(input int unsigned width_log2,
                                               input int unsigned i);
    logic [ColW-1:0] col;
    int unsigned     rank;
    col = ColW'(1) << width_log2;
    if (i < width_log2) begin
      col = col | (ColW'(1) << i);
    end else if (i > width_log2) begin
      rank = 0;
      for (int unsigned v = 3; v < (32'd1 << width_log2); v++) begin
        if ((v & (v - 1)) != 0) begin
          if (rank == i - width_log2 - 1) col = col | ColW'(v);
          rank++;
        end
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/dec_column_match.sv
// Combinational compare of a syndrome against every data column of the selected mode.
module dec_column_match import dec_pkg::*; #(
  parameter  int unsigned MAX_W = 32,
  localparam int unsigned SW    = $clog2(MAX_W) + 1
) (
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    s,
  output logic [MAX_W-1:0] match
);

  logic [3:0][MAX_W-1:0] mode_match;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    for (genvar i = 0; i < MAX_W; i++) begin : g_col
      if ((8 << m) <= MAX_W && i < (8 << m)) begin : g_on
        localparam logic [ColW-1:0] Col = dec_col(ModeLog2Base + m, i);
        assign mode_match[m][i] = (s == Col[SW-1:0]);
      end else begin : g_off
        assign mode_match[m][i] = 1'b0;
      end
    end
  end

  // Modes wider than MAX_W select an all-zero vector.
  assign match = mode_match[mode];

endmodule

// File: rtl/dec_syndrome_locator.sv
// Two-stage SEC-DED syndrome classifier with valid/ready handshakes.
// Optional DEC_ERR_CNT_EN adds saturating corrected/uncorrectable counters.
module dec_syndrome_locator import dec_pkg::*; #(
  parameter  int unsigned MAX_W = 32,
  localparam int unsigned SW    = $clog2(MAX_W) + 1,
  localparam int unsigned PW    = $clog2(MAX_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] s,
  input  logic [1:0]    codeword_width,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    status,
  output logic [PW-1:0] err_pos
`ifdef DEC_ERR_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [15:0]   corr_cnt,
  output logic [15:0]   uncorr_cnt
`endif
);

  localparam logic [1:0] MaxMode = (MAX_W >= 64) ? ModeW64 :
                                   (MAX_W >= 32) ? ModeW32 :
                                   (MAX_W >= 16) ? ModeW16 : ModeW8;

  logic [MAX_W-1:0] match;
  logic             s1_valid_q;
  logic [MAX_W-1:0] s1_match_q;
  logic [1:0]       s1_mode_q;
  logic [SW-1:0]    s1_s_q;
  logic             s2_valid_q;
  dec_status_e      status_q, status_d;
  logic [PW-1:0]    err_pos_q, err_pos_d;
  logic             s1_adv;
  logic             high_bits_set;

  dec_column_match #(
    .MAX_W(MAX_W)
  ) u_column_match (
    .mode (codeword_width),
    .s    (s),
    .match(match)
  );

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  always_comb begin
    status_d      = StUncorr;
    err_pos_d     = '0;
    high_bits_set = 1'b0;
    for (int unsigned b = 0; b < SW; b++) begin
      if (b > mode_log2(s1_mode_q) && s1_s_q[b]) high_bits_set = 1'b1;
    end
    if (s1_mode_q > MaxMode) begin
      status_d = StUncorr;
    end else if (s1_s_q == '0) begin
      status_d = StClean;
    end else if (|s1_match_q) begin
      // Data columns outrank check bits; the lowest matching index wins.
      status_d = StDataErr;
      for (int i = MAX_W - 1; i >= 0; i--) begin
        if (s1_match_q[i]) err_pos_d = PW'(i);
      end
    end else if (!high_bits_set && $onehot(s1_s_q)) begin
      status_d = StChkErr;
      for (int j = SW - 1; j >= 0; j--) begin
        if (s1_s_q[j]) err_pos_d = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      status_q   <= StClean;
      err_pos_q  <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s1_adv) s2_valid_q <= s1_valid_q;
      if (s1_adv && s1_valid_q) begin
        status_q  <= status_d;
        err_pos_q <= err_pos_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_match_q <= match;
      s1_mode_q  <= codeword_width;
      s1_s_q     <= s;
    end
  end

  assign out_valid = s2_valid_q;
  assign status    = status_q;
  assign err_pos   = err_pos_q;

`ifdef DEC_ERR_CNT_EN
  logic out_fire;
  assign out_fire = s2_valid_q && out_ready;

  // Clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (status_q == StUncorr) begin
        if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
      end else if (status_q != StClean) begin
        if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dec_syndrome_locator.sv
// Scoreboard bench for dec_syndrome_locator: directed steps, handshake stress, reset flush.
module tb_dec_syndrome_locator;

  localparam int unsigned MAX_W = 32;
  localparam logic [1:0] CLEAN = 2'd0, DATA = 2'd1, CHK = 2'd2, UNC = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] s = '0;
  logic [1:0] codeword_width = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] status;
  logic [4:0] err_pos;
`ifdef DEC_ERR_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] corr_cnt, uncorr_cnt;
`endif

  int         tests = 0;
  int         fails = 0;
  int         n_out = 0;
  int         n_start;
  logic       toggle_en = 1'b0;
  logic [1:0] exp_status_in = '0;
  logic [4:0] exp_pos_in = '0;
  logic [6:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [1:0] prev_status = '0;
  logic [4:0] prev_pos = '0;

  dec_syndrome_locator #(
    .MAX_W(MAX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .s             (s),
    .codeword_width(codeword_width),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .status        (status),
    .err_pos       (err_pos)
`ifdef DEC_ERR_CNT_EN
    ,
    .cnt_clr       (cnt_clr),
    .corr_cnt      (corr_cnt),
    .uncorr_cnt    (uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      out_ready = ~out_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: walk the data columns in index order, then check bits.
  function automatic logic [6:0] model(input logic [1:0] mode, input logic [5:0] syn);
    int unsigned k, w, idx;
    logic [5:0]  col;
    k = 3 + 32'(mode);
    w = 32'd1 << k;
    if (w > MAX_W) return {UNC, 5'd0};
    if (syn == 6'd0) return {CLEAN, 5'd0};
    for (int unsigned i = 0; i <= k; i++) begin
      col = 6'(32'd1 << k) | ((i < k) ? 6'(32'd1 << i) : 6'd0);
      if (syn == col) return {DATA, 5'(i)};
    end
    idx = k + 1;
    for (int unsigned v = 3; v < w; v++) begin
      if ($countones(v) > 1) begin
        if (syn == (6'(32'd1 << k) | 6'(v))) return {DATA, 5'(idx)};
        idx++;
      end
    end
    if ((syn >> (k + 1)) != 6'd0) return {UNC, 5'd0};
    if ($countones(syn) == 1) begin
      for (int j = 0; j < 6; j++) if (syn[j]) return {CHK, 5'(j)};
    end
    return {UNC, 5'd0};
  endfunction

  // Scoreboard and handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [6:0] e;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_status", 32'(status), 32'(prev_status));
      check("hold_pos", 32'(err_pos), 32'(prev_pos));
    end
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 || out_ready));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_status", 32'(status), 32'(e[6:5]));
          check("out_pos", 32'(err_pos), 32'(e[4:0]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back({exp_status_in, exp_pos_in});
      prev_stall  = out_valid && !out_ready;
      prev_status = status;
      prev_pos    = err_pos;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] mode, input logic [5:0] syn, input logic [6:0] exp);
    bit done;
    done           = 1'b0;
    codeword_width = mode;
    s              = syn;
    {exp_status_in, exp_pos_in} = exp;
    in_valid       = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] m;
    logic [5:0] v;

    cyc();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_status", 32'(status), 32'(CLEAN));
    check("rst_err_pos", 32'(err_pos), 32'd0);
`ifdef DEC_ERR_CNT_EN
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
`endif
    cyc();

    // Two-cycle latency on an empty pipeline.
    send(2'd2, 6'b100001, {DATA, 5'd0});
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_status", 32'(status), 32'(DATA));
    check("lat_cycle2_pos", 32'(err_pos), 32'd0);
    cyc();

    send(2'd0, 6'b001111, {DATA, 5'd7});
    send(2'd0, 6'b000100, {CHK, 5'd2});
    send(2'd0, 6'b000000, {CLEAN, 5'd0});
    send(2'd1, 6'b110000, {UNC, 5'd0});
    send(2'd3, 6'b000001, {UNC, 5'd0});
    send(2'd3, 6'b000000, {UNC, 5'd0});
    send(2'd0, 6'b001000, {DATA, 5'd3});
    send(2'd2, 6'b100000, {DATA, 5'd5});
    send(2'd2, 6'b111111, {DATA, 5'd31});
    send(2'd2, 6'b010000, {CHK, 5'd4});
    send(2'd0, 6'b010000, {UNC, 5'd0});
    wait_drain();

    // Back-to-back stream with out_ready toggling every cycle.
    n_start   = n_out;
    out_ready = 1'b1;
    toggle_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m = 2'($urandom_range(0, 3));
      v = 6'($urandom);
      send(m, v, model(m, v));
    end
    wait_drain();
    check("stream_count", 32'(n_out - n_start), 32'd10);
    toggle_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset with two results in flight.
    out_ready = 1'b0;
    send(2'd2, 6'b100010, {DATA, 5'd1});
    send(2'd0, 6'b000001, {CHK, 5'd0});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_status", 32'(status), 32'(CLEAN));
    check("flush_err_pos", 32'(err_pos), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_stale", 32'(out_valid), 32'd0);
    end
    cyc();

`ifdef DEC_ERR_CNT_EN
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    repeat (65534) send(2'd0, 6'b001111, {DATA, 5'd7});
    wait_drain();
    @(negedge clk);
    check("corr_cnt_preload", 32'(corr_cnt), 32'hFFFE);
    cyc();
    repeat (3) send(2'd0, 6'b001111, {DATA, 5'd7});
    wait_drain();
    @(negedge clk);
    check("corr_cnt_saturate", 32'(corr_cnt), 32'hFFFF);
    cyc();
    repeat (2) send(2'd1, 6'b110000, {UNC, 5'd0});
    wait_drain();
    @(negedge clk);
    check("uncorr_cnt_two", 32'(uncorr_cnt), 32'd2);
    cyc();
    out_ready = 1'b0;
    send(2'd1, 6'b110000, {UNC, 5'd0});
    cyc();
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(negedge clk);
    check("clr_fire_valid", 32'(out_valid), 32'd1);
    cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    check("clr_corr_cnt", 32'(corr_cnt), 32'd0);
    cyc();
`endif

    wait_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
